// File: rtl/ahb_master_arbiter.sv
// Two-requester AHB-lite master: instruction fetch (IF) and load/store (D) share one
// non-pipelined master port. All bus outputs and handshake pulses are registered.
module ahb_master_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned D_PRIO     = 1,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned WAIT_MAX   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic              bus_err,
    output logic              busy
);

    localparam int unsigned WaitW   = $clog2(WAIT_MAX + 1);
    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;      // 1: D owns the transfer, 0: IF
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic [StarveW-1:0]  if_starve_q, if_starve_d;
    logic [StarveW-1:0]  d_starve_q, d_starve_d;
    logic [1:0]          htrans_q, htrans_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic                if_gnt_q, if_gnt_d;
    logic                d_gnt_q, d_gnt_d;
    logic                if_done_q, if_done_d;
    logic                d_done_q, d_done_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                bus_err_q, bus_err_d;

    logic both_req;
    logic pick_d;       // arbitration result: 1 selects D
    logic finish;
    logic err;

    // Next-state, arbitration and registered-output computation
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        if_starve_d = if_starve_q;
        d_starve_d  = d_starve_q;
        htrans_d    = htrans_q;
        hwdata_d    = hwdata_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_err_d   = 1'b0;
        finish      = 1'b0;
        err         = 1'b0;

        both_req = if_req && d_req;
        if (!both_req) begin
            pick_d = d_req;
        end else if (D_PRIO != 0) begin
            pick_d = (if_starve_q != StarveW'(STARVE_MAX));
        end else begin
            pick_d = (d_starve_q == StarveW'(STARVE_MAX));
        end

        unique case (state_q)
            StIdle: begin
                if (if_req || d_req) begin
                    owner_d  = pick_d;
                    addr_d   = pick_d ? d_addr : if_addr;
                    write_d  = pick_d && d_write;
                    wdata_d  = pick_d ? d_wdata : '0;
                    htrans_d = 2'b10;
                    d_gnt_d  = pick_d;
                    if_gnt_d = !pick_d;
                    state_d  = StAddr;
                    // Winner's loss streak clears; a contended loser's streak saturates upward
                    if (pick_d) begin
                        d_starve_d = '0;
                        if (both_req && (if_starve_q != StarveW'(STARVE_MAX))) begin
                            if_starve_d = if_starve_q + 1'b1;
                        end
                    end else begin
                        if_starve_d = '0;
                        if (both_req && (d_starve_q != StarveW'(STARVE_MAX))) begin
                            d_starve_d = d_starve_q + 1'b1;
                        end
                    end
                end
            end
            StAddr: begin
                if (HREADY) begin
                    htrans_d = 2'b00;
                    hwdata_d = write_q ? wdata_q : '0;
                    wait_d   = '0;
                    state_d  = StData;
                end
            end
            StData: begin
                if (HREADY) begin
                    finish = 1'b1;
                    err    = HRESP;
                end else if (wait_q == WaitW'(WAIT_MAX - 1)) begin
                    // This is the WAIT_MAX-th stalled cycle: give up on the slave
                    finish = 1'b1;
                    err    = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
                if (finish) begin
                    state_d   = StIdle;
                    hwdata_d  = '0;
                    wait_d    = '0;
                    bus_err_d = err;
                    d_done_d  = owner_q;
                    if_done_d = !owner_q;
                    if (!err) begin
                        if (owner_q) begin
                            d_rdata_d = HRDATA;
                        end else begin
                            if_rdata_d = HRDATA;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset kills any transfer in flight without a done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            wait_q      <= '0;
            if_starve_q <= '0;
            d_starve_q  <= '0;
            htrans_q    <= 2'b00;
            hwdata_q    <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            if_starve_q <= if_starve_d;
            d_starve_q  <= d_starve_d;
            htrans_q    <= htrans_d;
            hwdata_q    <= hwdata_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign HADDR    = addr_q;
    assign HTRANS   = htrans_q;
    assign HWRITE   = write_q;
    assign HSIZE    = 3'b010;
    assign HWDATA   = hwdata_q;
    assign if_gnt   = if_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign if_done  = if_done_q;
    assign d_done   = d_done_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign bus_err  = bus_err_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter: scoreboard of expected completions plus
// cycle-accurate latency, bus-signal, starvation, error, timeout and reset checks.
module tb_ahb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_write;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_done, d_gnt, d_done;
    logic [31:0] if_rdata, d_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP, bus_err, busy;
    logic [2:0]  HSIZE;

    typedef struct packed {
        logic        own_d;
        logic        chk;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc;
    logic got;
    logic exp_own;

    ahb_master_arbiter #(
        .ADDR_W(32), .DATA_W(32), .D_PRIO(1), .STARVE_MAX(4), .WAIT_MAX(15)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .if_rdata(if_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .bus_err(bus_err), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic push_exp(input logic own, input logic chk, input logic err,
                            input logic [31:0] rd);
        exp_t e;
        e.own_d = own;
        e.chk   = chk;
        e.err   = err;
        e.rdata = rd;
        sb_q.push_back(e);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Completion monitor: every done pulse must match the oldest expected transfer
    always @(negedge clk) begin
        exp_t e;
        if (if_gnt || d_gnt) check_eq("gnt_onehot", {if_gnt, d_gnt} != 2'b11, 1);
        if (if_done || d_done) begin
            check_eq("done_onehot", {if_done, d_done} != 2'b11, 1);
            check_eq("done_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("done_owner", d_done, e.own_d);
                check_eq("done_bus_err", bus_err, e.err);
                if (e.chk) check_eq("done_rdata", e.own_d ? d_rdata : if_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; if_req = 0; d_req = 0; d_write = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
        tick; tick;
        check_eq("rst_htrans", HTRANS, 2'b00);
        check_eq("rst_haddr", HADDR, 0);
        check_eq("rst_hwrite_hwdata", {HWRITE, HWDATA}, 0);
        check_eq("rst_pulses", {if_gnt, d_gnt, if_done, d_done, bus_err, busy}, 0);
        check_eq("rst_rdata", {if_rdata, d_rdata}, 0);
        check_eq("hsize", HSIZE, 3'b010);
        rst = 1'b1;
        tick;

        // 1: D load, zero wait states
        d_req = 1; d_write = 0; d_addr = 32'h100; HRDATA = 32'hDEADBEEF;
        push_exp(1, 1, 0, 32'hDEADBEEF);
        check_eq("t1_c0_busy", busy, 0);
        tick;  // cycle 1
        check_eq("t1_gnt", d_gnt, 1);
        check_eq("t1_htrans_nonseq", HTRANS, 2'b10);
        check_eq("t1_haddr", HADDR, 32'h100);
        check_eq("t1_hwrite", HWRITE, 0);
        check_eq("t1_busy", busy, 1);
        d_req = 0;
        tick;  // cycle 2
        check_eq("t1_data_htrans", HTRANS, 2'b00);
        check_eq("t1_c2_done", d_done, 0);
        tick;  // cycle 3
        check_eq("t1_done_c3", d_done, 1);
        check_eq("t1_rdata", d_rdata, 32'hDEADBEEF);
        HRDATA = 0;

        // 2: D store with two stalled data cycles
        d_req = 1; d_write = 1; d_addr = 32'h200; d_wdata = 32'h55AA55AA;
        push_exp(1, 0, 0, 0);
        tick;  // cycle 1
        check_eq("t2_gnt", d_gnt, 1);
        check_eq("t2_hwrite", HWRITE, 1);
        check_eq("t2_haddr", HADDR, 32'h200);
        d_req = 0; d_write = 0;
        tick;  // cycle 2
        check_eq("t2_hwdata_c2", HWDATA, 32'h55AA55AA);
        HREADY = 0;
        tick;  // cycle 3
        check_eq("t2_hwdata_c3", HWDATA, 32'h55AA55AA);
        check_eq("t2_no_done_c3", d_done, 0);
        tick;  // cycle 4
        check_eq("t2_hwdata_c4", HWDATA, 32'h55AA55AA);
        check_eq("t2_no_done_c4", d_done, 0);
        HREADY = 1;
        tick;  // cycle 5
        check_eq("t2_done_c5", d_done, 1);
        check_eq("t2_bus_err", bus_err, 0);

        // 3: both requesters held, D priority with starvation relief for IF
        if_addr = 32'h1000; d_addr = 32'h2000; HRDATA = 32'hA5A50003;
        for (int n = 0; n < 10; n++) push_exp((n % 5) != 4, 1, 0, 32'hA5A50003);
        if_req = 1; d_req = 1;
        for (int n = 0; n < 10; n++) begin
            got = 0;
            for (int k = 0; k < 8; k++) begin
                tick;
                if (if_gnt || d_gnt) begin
                    got = 1;
                    break;
                end
            end
            check_eq("t3_gnt_seen", got, 1);
            exp_own = (n % 5) != 4;
            check_eq("t3_winner", d_gnt, exp_own);
            check_eq("t3_haddr", HADDR, exp_own ? 32'h2000 : 32'h1000);
            if (n == 9) begin
                if_req = 0; d_req = 0;
            end
        end
        for (int k = 0; k < 10; k++) begin
            if (sb_q.size() == 0) break;
            tick;
        end
        check_eq("t3_drained", sb_q.size(), 0);

        // 4: IF read gets ERROR response, then a clean IF read
        if_req = 1; if_addr = 32'h300;
        push_exp(0, 0, 1, 0);
        tick;  // cycle 1
        check_eq("t4_gnt", if_gnt, 1);
        if_req = 0;
        tick;  // cycle 2
        HRESP = 1;
        tick;  // cycle 3
        check_eq("t4_err_done", {if_done, bus_err}, 2'b11);
        HRESP = 0;
        if_req = 1; if_addr = 32'h304; HRDATA = 32'hCAFEF00D;
        push_exp(0, 1, 0, 32'hCAFEF00D);
        tick;  // cycle 1
        check_eq("t4b_gnt", if_gnt, 1);
        check_eq("t4b_haddr", HADDR, 32'h304);
        if_req = 0;
        tick; tick;  // cycle 3
        check_eq("t4b_done", if_done, 1);
        check_eq("t4b_no_err", bus_err, 0);
        check_eq("t4b_rdata", if_rdata, 32'hCAFEF00D);

        // 5: HREADY stuck low in the data phase -> timeout abort
        d_req = 1; d_write = 0; d_addr = 32'h400;
        push_exp(1, 0, 1, 0);
        tick;  // cycle 1
        check_eq("t5_gnt", d_gnt, 1);
        d_req = 0;
        tick;  // cycle 2
        HREADY = 0;
        cyc = 2;
        for (int k = 0; k < 40; k++) begin
            tick;
            cyc++;
            if (d_done) break;
        end
        check_eq("t5_done_cycle", cyc, 17);
        check_eq("t5_bus_err", bus_err, 1);
        check_eq("t5_idle_at_done", busy, 0);
        HREADY = 1;
        tick;
        check_eq("t5_busy_after", busy, 0);

        // 6: reset asserted during the address phase
        d_req = 1; d_addr = 32'h500;
        tick;  // cycle 1
        check_eq("t6_nonseq", HTRANS, 2'b10);
        rst = 0; d_req = 0;
        #1;
        check_eq("t6_async_htrans", HTRANS, 2'b00);
        check_eq("t6_async_busy", busy, 0);
        check_eq("t6_async_gnt", d_gnt, 0);
        tick; tick;
        rst = 1;
        for (int k = 0; k < 6; k++) begin
            tick;
            check_eq("t6_no_done", {if_done, d_done, busy}, 0);
        end
        check_eq("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
